uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit path (wr_uart/w_data/tx_full of the uart block) among NREQ

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of requester-side handshake and UART write-side signals used by
// uart_tx_arbiter.
//   req_valid/req_last/req_data : requester byte streams (req_data[i] = byte i)
//   req_ready                   : per-requester accept qualifier
//   tx_full                     : UART TX FIFO full flag
//   wr_uart/w_data              : registered write strobe/byte into the FIFO
//   grant/busy/timeout          : arbitration status
// Modports: slave = arbiter side, master = requesters + UART side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0][7:0]  req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_full;
  logic                  wr_uart;
  logic [7:0]            w_data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  timeout;

  modport slave (
    input  req_valid, req_last, req_data, tx_full,
    output req_ready, wr_uart, w_data, grant, busy, timeout
  );

  modport master (
    output req_valid, req_last, req_data, tx_full,
    input  req_ready, wr_uart, w_data, grant, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX FIFO write port among NREQ byte-stream requesters.
// Round-robin arbitration at packet granularity: a granted requester keeps
// the write port until its byte flagged 'last' is accepted.
//
// Ports:
//   i_clk    : clock, all logic on rising edge
//   i_reset  : synchronous active-high reset
//   bus      : uart_tx_arbiter_if.slave (requester handshake, UART write side,
//              grant/busy/timeout status)
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   Defined   -> grant revoked after TO_CYC cycles of req_valid[g]=0 mid-packet,
//                with a one-cycle timeout pulse.
//   Undefined -> timeout tied 0, grant held until the last byte.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int TO_CYC = 1023,
  parameter int TO_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_tx_arbiter_if.slave  bus
);

  // Elaboration-time configuration sanity checks.
  if ((1 << IDW) < NREQ) begin : g_idw_chk
    $error("uart_tx_arbiter: IDW too narrow for NREQ");
  end
  if (TO_CYC < 2 || TO_CYC >= (1 << TO_W)) begin : g_to_chk
    $error("uart_tx_arbiter: TO_W cannot hold TO_CYC");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_gidx, w_gidx_nxt;   // index of current owner
  logic [IDW-1:0]  r_ptr,  w_ptr_nxt;    // last served requester
  logic [IDW-1:0]  w_pick;
  logic            w_any;
  logic            r_wr;
  logic [7:0]      r_data;
  logic            r_to;
  logic            w_busy, w_rdy, w_vld_g, w_last_g, w_accept;
  logic            w_to_hit, w_to_fire;

  assign w_busy   = (r_state == BUSY);
  assign w_vld_g  = bus.req_valid[r_gidx];
  assign w_last_g = bus.req_last[r_gidx];
  // ~r_wr leaves one cycle for tx_full to reflect the write just issued,
  // so the FIFO cannot be overrun.
  assign w_rdy    = w_busy & ~bus.tx_full & ~r_wr;
  assign w_accept = w_rdy & w_vld_g;

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign bus.req_ready[i] = w_rdy && (r_gidx == IDW'(i));
  end

  // Round-robin pick: scan ptr+1, ptr+2, ... ; descending loop so the
  // closest requester after ptr is the final (winning) assignment.
  always_comb begin
    logic [IDW-1:0] idx;
    w_pick = '0;
    w_any  = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (bus.req_valid[idx]) begin
        w_pick = idx;
        w_any  = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Only cycles where the owner itself is idle count; stalls caused by
  // tx_full / write spacing hold the counter.
  assign w_to_hit = w_busy && !w_vld_g && (r_to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset)                    r_to_cnt <= '0;
    else if (!w_busy || w_accept)   r_to_cnt <= '0;
    else if (!w_vld_g)              r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_to_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gidx_nxt  = w_pick;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_last_g) begin
          // finished owner drops to lowest priority
          w_ptr_nxt   = r_gidx;
          w_state_nxt = IDLE;
        end else if (w_to_hit) begin
          w_ptr_nxt   = r_gidx;
          w_state_nxt = IDLE;
          w_to_fire   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_gidx  <= '0;
      r_ptr   <= IDW'(NREQ - 1);
      r_wr    <= 1'b0;
      r_data  <= 8'h00;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wr    <= w_accept;
      r_to    <= w_to_fire;
      if (w_accept) r_data <= bus.req_data[r_gidx];
    end
  end

  assign bus.wr_uart = r_wr;
  assign bus.w_data  = r_data;
  assign bus.busy    = w_busy;
  assign bus.timeout = r_to;
  assign bus.grant   = w_busy ? (NREQ'(1) << r_gidx) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ   = 4;
  localparam int TO_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
  uart_tx_arbiter #(.NREQ(NREQ), .IDW(2), .TO_CYC(TO_CYC), .TO_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));

  // requester packet queues: {last, byte}
  logic [8:0]       q[NREQ][$];
  logic [NREQ-1:0]  en = '0;
  logic             txf = 1'b0;

  // reference model: owner index (-1 idle), rr pointer, registered outputs
  int         m_own = -1, m_ptr = NREQ - 1, m_cnt = 0;
  logic       m_wr = 1'b0, m_to = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         started = 0;

  int vectors = 0, miscompares = 0, n_to = 0;
  logic [7:0]       wlog[$];
  logic [NREQ-1:0]  glog[$];
  logic [NREQ-1:0]  prev_grant = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = en[i] && (q[i].size() > 0);
      bus.req_data[i]  = (q[i].size() > 0) ? q[i][0][7:0] : 8'($urandom);
      bus.req_last[i]  = (q[i].size() > 0) ? q[i][0][8]   : 1'($urandom);
    end
    bus.tx_full = txf;
  endtask

  task automatic cyc();
    logic [NREQ-1:0] exp_rdy, exp_g;
    int g;
    drive();
    #1;
    exp_rdy = '0;
    if (m_own >= 0 && !txf && !m_wr) exp_rdy[m_own] = 1'b1;
    if (started) chk("req_ready", bus.req_ready, exp_rdy);
    // model next state from the spec rules
    if (rst) begin
      m_own = -1; m_ptr = NREQ - 1; m_wr = 0; m_data = 0; m_to = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      m_wr = 0; m_to = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (bus.req_valid[c]) begin m_own = c; m_cnt = 0; break; end
      end
    end else begin
      g = m_own;
      m_wr = bus.req_valid[g] && exp_rdy[g];
      m_to = 0;
      if (m_wr) begin
        m_data = q[g][0][7:0];
        m_cnt  = 0;
        if (q[g][0][8]) begin m_ptr = g; m_own = -1; end
        void'(q[g].pop_front());
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (!bus.req_valid[g]) begin
        if (m_cnt == TO_CYC - 1) begin m_to = 1; m_ptr = g; m_own = -1; end
        else m_cnt++;
      end
`endif
    end
    @(posedge clk);
    #1;
    started = 1;
    exp_g = (m_own < 0) ? '0 : (NREQ'(1) << m_own);
    chk("grant",   bus.grant,   exp_g);
    chk("busy",    bus.busy,    m_own >= 0);
    chk("wr_uart", bus.wr_uart, m_wr);
    chk("timeout", bus.timeout, m_to);
    if (m_wr || rst) chk("w_data", bus.w_data, m_data);
    if (bus.wr_uart === 1'b1) wlog.push_back(bus.w_data);
    if (bus.timeout === 1'b1) n_to++;
    if (bus.grant != '0 && prev_grant == '0) glog.push_back(bus.grant);
    prev_grant = bus.grant;
  endtask

  task automatic do_reset();
    rst = 1; en = '0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    cyc();
    rst = 0;
    wlog.delete(); glog.delete();
  endtask

  task automatic drain(string tag, int max);
    int left, n;
    n = 0;
    left = 1;
    while (left != 0 && n < max) begin
      cyc();
      n++;
      left = (m_own >= 0 || m_wr) ? 1 : 0;
      for (int i = 0; i < NREQ; i++) left += q[i].size();
    end
    chk(tag, left, 0);
  endtask

  task automatic wait_writes(string tag, int nw, int max);
    int n;
    n = 0;
    while (wlog.size() < nw && n < max) begin cyc(); n++; end
    chk(tag, wlog.size(), nw);
  endtask

  function automatic logic [31:0] wl(int k);
    return (wlog.size() > k) ? {24'h0, wlog[k]} : 32'hdead;
  endfunction

  function automatic logic [31:0] gl(int k);
    return (glog.size() > k) ? {28'h0, glog[k]} : 32'hdead;
  endfunction

  initial begin
    // reset state
    txf = 0;
    do_reset();
    do_reset();

    // T1: single requester, 3-byte packet
    q[0].push_back(9'h0A1); q[0].push_back(9'h0A2); q[0].push_back(9'h1A3);
    en = 4'b0001;
    drain("t1_drain", 40);
    chk("t1_nbytes", wlog.size(), 3);
    chk("t1_b0", wl(0), 8'hA1);
    chk("t1_b1", wl(1), 8'hA2);
    chk("t1_b2", wl(2), 8'hA3);
    chk("t1_grant", gl(0), 4'b0001);

    // T2: all four with 1-byte packets -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, 8'(8'h10 * i + j)});
    en = 4'b1111;
    drain("t2_drain", 80);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_grant%0d", k), gl(k), NREQ'(1) << (k % 4));
      chk($sformatf("t2_data%0d", k), wl(k), 8'h10 * (k % 4) + k / 4);
    end

    // T3: tx_full stall mid-packet
    do_reset();
    for (int b = 0; b < 4; b++) q[1].push_back({b == 3, 8'(8'hC0 + b)});
    en = 4'b0010;
    wait_writes("t3_first", 1, 20);
    txf = 1;
    repeat (20) cyc();
    chk("t3_stall", wlog.size(), 1);
    txf = 0;
    drain("t3_drain", 40);
    chk("t3_nbytes", wlog.size(), 4);
    for (int b = 0; b < 4; b++) chk($sformatf("t3_b%0d", b), wl(b), 8'hC0 + b);

    // T6: last of req1 while req1 and req3 valid -> req3 next
    do_reset();
    q[1].push_back(9'h111); q[1].push_back(9'h112); q[3].push_back(9'h133);
    en = 4'b1010;
    drain("t6_drain", 40);
    chk("t6_g0", gl(0), 4'b0010);
    chk("t6_g1", gl(1), 4'b1000);
    chk("t6_g2", gl(2), 4'b0010);

    // T5: reset mid-packet; ptr returns so req0 beats req1
    do_reset();
    q[0].push_back(9'h150); en = 4'b0001;
    drain("t5_pre", 20);
    for (int b = 0; b < 4; b++) q[2].push_back({b == 3, 8'(8'h20 + b)});
    en = 4'b0100;
    wait_writes("t5_two", 3, 30);
    do_reset();
    chk("t5_rst_grant", bus.grant, 0);
    chk("t5_rst_wr", bus.wr_uart, 0);
    q[0].push_back(9'h151); q[1].push_back(9'h152);
    en = 4'b0011;
    drain("t5_drain", 40);
    chk("t5_winner", gl(0), 4'b0001);

    // T4: owner drops valid mid-packet while req0 waits
    do_reset();
    q[2].push_back(9'h041); q[2].push_back(9'h142); q[0].push_back(9'h105);
    en = 4'b0100;
    wait_writes("t4_first", 1, 20);
    en = 4'b0001;
    n_to = 0;
    repeat (20) cyc();
`ifdef UART_ARB_TIMEOUT_EN
    chk("t4_to_pulses", n_to, 1);
    chk("t4_regrant", gl(1), 4'b0001);
`else
    chk("t4_to_pulses", n_to, 0);
    chk("t4_hold", bus.grant, 4'b0100);
`endif
    en = 4'b0101;
    drain("t4_drain", 60);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(99) < 6 && q[i].size() < 8) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) q[i].push_back({b == len - 1, 8'($urandom)});
        end
        en[i] = ($urandom_range(99) < 85);
      end
      txf = ($urandom_range(99) < 20);
      cyc();
    end
    en = '1; txf = 0;
    drain("rand_drain", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
